// File: rtl/clb_pkg.sv
// clb_pkg: shared sizing functions, load-FSM encoding and config field offsets for the CLB cluster.
// Latency: none; this file holds only types, constants and constant functions.
// Backpressure: none.
package clb_pkg;

  localparam int DEF_LUT_K   = 4;
  localparam int DEF_BLE_NUM = 4;
  localparam int DEF_IN_NUM  = 10;

  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    SHIFT  = 2'd1,
    ACTIVE = 2'd2
  } cfg_state_t;

  // Crossbar select width: one code per cluster input plus one per BLE feedback.
  function automatic int sel_w_f(input int in_num, input int ble_num);
    return $clog2(in_num + ble_num);
  endfunction

  // Config bits per BLE: truth table, mode bit, one select field per LUT input.
  function automatic int ble_cfg_f(input int lut_k, input int sel_w);
    return (2 ** lut_k) + 1 + lut_k * sel_w;
  endfunction

  function automatic int cfg_bits_f(input int lut_k, input int in_num, input int ble_num);
    return ble_num * ble_cfg_f(lut_k, sel_w_f(in_num, ble_num));
  endfunction

  // Field offsets relative to a BLE's base address in the chain.
  function automatic int mode_off_f(input int lut_k);
    return 2 ** lut_k;
  endfunction

  function automatic int sel_off_f(input int lut_k, input int k, input int sel_w);
    return (2 ** lut_k) + 1 + k * sel_w;
  endfunction

endpackage

// File: rtl/clb_if.sv
// clb_if: fabric-side bundle of the CLB cluster (data inputs/outputs, FF enable, scan chain, status).
// Latency: none; wiring only.
// Backpressure: none; the scan chain accepts one bit per cycle whenever scan_en is high.
// Ports: ce, in, scan_en, scan_in driven by the master; out, scan_out, cfg_done, cfg_err driven by the slave.
interface clb_if import clb_pkg::*; #(
  parameter int IN_NUM  = DEF_IN_NUM,
  parameter int BLE_NUM = DEF_BLE_NUM
);
  logic               ce;
  logic [IN_NUM-1:0]  in;
  logic [BLE_NUM-1:0] out;
  logic               scan_en;
  logic               scan_in;
  logic               scan_out;
  logic               cfg_done;
  logic               cfg_err;

  modport master (
    output ce, in, scan_en, scan_in,
    input  out, scan_out, cfg_done, cfg_err
  );

  modport slave (
    input  ce, in, scan_en, scan_in,
    output out, scan_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/ble_lut.sv
// ble_lut: one basic logic element - LUT_K-input LUT, mode mux and a single FF.
// Latency: combinational mode is same-cycle; registered mode updates one cycle after an edge with ce=1.
// Backpressure: none; hold freezes the FF, clr forces it to 0 (clr has priority).
// Ports: clk, rst_n (sync, active low), ce, hold, clr, cfg = {mode, truth table}, lut_in, q (FF), ble_out.
module ble_lut import clb_pkg::*; #(
  parameter int LUT_K = DEF_LUT_K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             hold,
  input  logic             clr,
  input  logic [2**LUT_K:0] cfg,
  input  logic [LUT_K-1:0] lut_in,
  output logic             q,
  output logic             ble_out
);

  localparam int MODE = mode_off_f(LUT_K);

  logic [2**LUT_K-1:0] tt;
  logic                lut_val;

  assign tt      = cfg[2**LUT_K-1:0];
  assign lut_val = tt[lut_in];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (!hold && ce) begin
      q <= lut_val;
    end
  end

  // mode=1 bypasses the FF.
  assign ble_out = cfg[MODE] ? lut_val : q;

endmodule

// File: rtl/clb_cluster.sv
// clb_cluster: BLE_NUM logic elements behind a local crossbar, configured through one serial scan chain.
// Latency: comb-mode in->out same cycle; reg-mode one cycle after ce; cfg_done one cycle after scan_en falls on an exact load.
// Backpressure: none; scan_en shifts every cycle it is high, outputs stay 0 until a complete exact-length load.
// Ports: clk, rst_n (sync, active low), bus (clb_if.slave: ce, in, out, scan_en, scan_in, scan_out, cfg_done, cfg_err).
module clb_cluster import clb_pkg::*; #(
  parameter int LUT_K   = DEF_LUT_K,
  parameter int BLE_NUM = DEF_BLE_NUM,
  parameter int IN_NUM  = DEF_IN_NUM
) (
  input logic  clk,
  input logic  rst_n,
  clb_if.slave bus
);

  localparam int SEL_W    = sel_w_f(IN_NUM, BLE_NUM);
  localparam int BLE_CFG  = ble_cfg_f(LUT_K, SEL_W);
  localparam int CFG_BITS = cfg_bits_f(LUT_K, IN_NUM, BLE_NUM);
  localparam int SRC_NUM  = IN_NUM + BLE_NUM;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] chain;
  cfg_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                done_r, done_nxt;
  logic                err_r, err_nxt;
  logic                ble_hold, ble_clr;
  logic [BLE_NUM-1:0]  q;
  logic [BLE_NUM-1:0]  ble_out;
  logic [2**SEL_W-1:0] src;

  // Config chain: shifts towards bit 0, so the first bit in lands at address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (bus.scan_en) begin
      chain <= {bus.scan_in, chain[CFG_BITS-1:1]};
    end
  end

  assign bus.scan_out = chain[0];
  assign bus.cfg_done = done_r;
  assign bus.cfg_err  = err_r;

  // Load FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= UNCFG;
      cnt    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  // Load FSM: next state. The counter saturates one past full so any over-shift stays distinguishable.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done_r;
    err_nxt   = err_r;
    unique case (state)
      UNCFG, ACTIVE: begin
        if (bus.scan_en) begin
          state_nxt = SHIFT;
          cnt_nxt   = CNT_W'(1);
          done_nxt  = 1'b0;
        end
      end
      SHIFT: begin
        if (bus.scan_en) begin
          if (cnt != CNT_OVER) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (cnt == CNT_FULL) begin
          state_nxt = ACTIVE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end else begin
          state_nxt = UNCFG;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = UNCFG;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // Load FSM: outputs. FFs are frozen while shifting and cleared while unconfigured.
  always_comb begin
    ble_hold = (state != ACTIVE);
    ble_clr  = (state == UNCFG);
    bus.out  = (state == ACTIVE) ? ble_out : '0;
  end

  // Crossbar source vector; codes past the last real source read the zero padding.
  always_comb begin
    src = '0;
    src[SRC_NUM-1:0] = {q, bus.in};
  end

  for (genvar b = 0; b < BLE_NUM; b++) begin : g_ble
    localparam int BASE     = b * BLE_CFG;
    localparam int SEL_BASE = BASE + sel_off_f(LUT_K, 0, SEL_W);

    logic [LUT_K-1:0] lut_in;

    always_comb begin
      lut_in = '0;
      for (int k = 0; k < LUT_K; k++) begin
        lut_in[k] = src[chain[SEL_BASE + k*SEL_W +: SEL_W]];
      end
    end

    ble_lut #(.LUT_K(LUT_K)) u_ble (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (bus.ce),
      .hold    (ble_hold),
      .clr     (ble_clr),
      .cfg     (chain[BASE +: 2**LUT_K+1]),
      .lut_in  (lut_in),
      .q       (q[b]),
      .ble_out (ble_out[b])
    );
  end

endmodule

// File: tb/tb_clb_cluster.sv
// tb_clb_cluster: randomized scoreboard bench for clb_cluster against a queue-based behavioural model.
// Latency: expectations are queued as each cycle is driven and compared mid-cycle by an independent monitor.
// Backpressure: none.
module tb_clb_cluster;
  import clb_pkg::*;

  localparam int IN = 10;
  localparam int BN = 4;
  localparam int K  = 4;
  localparam int SW = 4;
  localparam int BC = 33;
  localparam int N  = BN * BC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clb_if #(.IN_NUM(IN), .BLE_NUM(BN)) bus ();

  clb_cluster #(.LUT_K(K), .BLE_NUM(BN), .IN_NUM(IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: the chain is a FIFO of bits, front = address 0.
  bit mchain[$];
  bit mq[BN];
  bit mact;
  bit mshift;
  bit merr;
  int mburst;

  typedef struct {
    logic [3:0] out;
    logic       so;
    logic       done;
    logic       err;
    int         cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [N-1:0] img;

  function automatic int fld(input int lo, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v |= int'(mchain[lo+i]) << i;
    return v;
  endfunction

  function automatic bit src_bit(input int s, input logic [IN-1:0] iv);
    if (s < IN) return iv[s];
    if (s < IN + BN) return mq[s-IN];
    return 1'b0;
  endfunction

  function automatic bit lut_of(input int b, input logic [IN-1:0] iv);
    int base = b * BC;
    int idx = 0;
    for (int k = 0; k < K; k++) idx |= int'(src_bit(fld(base + 17 + k*SW, SW), iv)) << k;
    return mchain[base + idx];
  endfunction

  function automatic logic [3:0] m_out(input logic [IN-1:0] iv);
    logic [3:0] o = '0;
    if (mact) begin
      for (int b = 0; b < BN; b++) o[b] = mchain[b*BC + 16] ? lut_of(b, iv) : mq[b];
    end
    return o;
  endfunction

  task automatic model_reset();
    mchain.delete();
    for (int i = 0; i < N; i++) mchain.push_back(1'b0);
    for (int b = 0; b < BN; b++) mq[b] = 1'b0;
    mact = 0; mshift = 0; merr = 0; mburst = 0;
  endtask

  task automatic model_edge(input logic r, input logic se, input logic si, input logic c,
                            input logic [IN-1:0] iv);
    bit nl[BN];
    for (int b = 0; b < BN; b++) nl[b] = lut_of(b, iv);
    if (!r) begin
      model_reset();
    end else begin
      if (!mact && !mshift) begin
        for (int b = 0; b < BN; b++) mq[b] = 1'b0;
      end else if (mact && c) begin
        for (int b = 0; b < BN; b++) mq[b] = nl[b];
      end
      if (se) begin
        mchain.push_back(si);
        void'(mchain.pop_front());
        mburst = mshift ? mburst + 1 : 1;
        mshift = 1;
        mact = 0;
      end else if (mshift) begin
        mshift = 0;
        if (mburst == N) begin
          mact = 1;
          merr = 0;
        end else begin
          merr = 1;
        end
      end
    end
  endtask

  // Drive one cycle at posedge+1, queue what the DUT should show during it, then step the model at the edge.
  task automatic drive(input logic r, input logic se, input logic si, input logic c,
                       input logic [IN-1:0] iv, input bit chk);
    exp_t e;
    rst_n = r;
    bus.scan_en = se;
    bus.scan_in = si;
    bus.ce = c;
    bus.in = iv;
    if (chk) begin
      e.out = m_out(iv);
      e.so = mchain[0];
      e.done = mact;
      e.err = merr;
      e.cy = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, se, si, c, iv);
    cyc++;
    #1;
  endtask

  task automatic cmp(input string nm, input int cy, input logic [3:0] a, input logic [3:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cy, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp("out", mon_e.cy, bus.out, mon_e.out);
      cmp("scan_out", mon_e.cy, {3'b0, bus.scan_out}, {3'b0, mon_e.so});
      cmp("cfg_done", mon_e.cy, {3'b0, bus.cfg_done}, {3'b0, mon_e.done});
      cmp("cfg_err", mon_e.cy, {3'b0, bus.cfg_err}, {3'b0, mon_e.err});
    end
  end

  task automatic set_ble(input int b, input logic [15:0] tt, input logic md, input logic [15:0] sels);
    int base = b * BC;
    for (int j = 0; j < 16; j++) img[base + j] = tt[j];
    img[base + 16] = md;
    for (int i = 0; i < 16; i++) img[base + 17 + i] = sels[i];
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) img[i] = 1'($urandom);
  endtask

  // Shift n bits (img first, random beyond N), then drop scan_en for one cycle.
  task automatic load(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, (i < N) ? img[i] : 1'($urandom), 1'($urandom), 10'($urandom), 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'($urandom), 10'($urandom), 1'b1);
  endtask

  task automatic run(input int n, input int ce_mode, input bit pulses);
    logic c;
    for (int i = 0; i < n; i++) begin
      c = (ce_mode == 2) ? 1'($urandom) : 1'(ce_mode);
      drive(1'b1, pulses && ($urandom_range(15) == 0), 1'($urandom), c, 10'($urandom), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    bus.scan_en = 1'b0;
    bus.scan_in = 1'b0;
    bus.ce = 1'b0;
    bus.in = '0;
    model_reset();

    // Reset: first edge only establishes known state, then two checked reset cycles.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'($urandom), 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 10'($urandom), 1'b1);

    // AND4 comb, XOR2 registered, self-toggling FF, random fourth BLE.
    rand_img();
    set_ble(0, 16'h8000, 1'b1, {4'd3, 4'd2, 4'd1, 4'd0});
    set_ble(1, 16'h6666, 1'b0, {4'd15, 4'd15, 4'd5, 4'd4});
    set_ble(2, 16'h5555, 1'b0, {4'd15, 4'd15, 4'd15, 4'd12});
    set_ble(3, 16'($urandom), 1'($urandom), 16'($urandom));
    load(N);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h00F, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h00E, 1'b1);
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 10'(p << 4), 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 10'(p << 4), 1'b1);
    end
    for (int p = 0; p < 4; p++) drive(1'b1, 1'b0, 1'b0, 1'b0, 10'(p << 4), 1'b1);
    run(8, 1, 1'b0);
    run(40, 2, 1'b0);

    // Length errors and recovery.
    rand_img();
    load(N - 1);
    run(3, 2, 1'b0);
    load(N + 8);
    run(3, 2, 1'b0);
    load(N);
    run(30, 2, 1'b0);

    // Readback by reshift, then a reset in the middle of a reshift.
    rand_img();
    load(N);
    run(10, 2, 1'b0);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 10'($urandom), 1'b1);
    drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 10'($urandom), 1'b1);
    run(3, 2, 1'b0);
    rand_img();
    load(N);
    run(20, 2, 1'b0);

    // Random loads of assorted lengths with occasional stray shift pulses.
    for (int t = 0; t < 8; t++) begin
      int len;
      rand_img();
      case ($urandom_range(3))
        0: len = N;
        1: len = N - 1;
        2: len = N + 1;
        default: len = $urandom_range(200, 1);
      endcase
      load(len);
      run(25, 2, (t % 2) == 1);
    end
    rand_img();
    load(N);
    run(30, 2, 1'b0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
